// File: rtl/vga_port_monitor_if.sv
// -----------------------------------------------------------------------------
// vga_port_monitor_if
//   Bundles the monitored CPU output ports, the freeze control and the
//   renderer's random-access read port of vga_port_monitor.
//
//   master : the environment side (CPU ports, freeze, renderer read address).
//   slave  : the monitor itself.
//
//   Signals
//     ports_flat  NUM_PORTS*PORT_W  port p at [p*PORT_W +: PORT_W]
//     freeze      1                 skip refresh ticks while high
//     rd_port     port index of the renderer read
//     rd_digit    digit index of the renderer read, 0 = ones
//     rd_data     6                 registered digit code or 6'h20 (blank)
//     busy        1                 conversion in progress
//     frame_done  1                 one-cycle pulse, new frame published
// -----------------------------------------------------------------------------
interface vga_port_monitor_if #(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 8,
  parameter int DIGITS    = 3
);
  logic [NUM_PORTS*PORT_W-1:0]                      ports_flat;
  logic                                             freeze;
  logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] rd_port;
  logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0]       rd_digit;
  logic [5:0]                                       rd_data;
  logic                                             busy;
  logic                                             frame_done;

  modport master (
    output ports_flat, freeze, rd_port, rd_digit,
    input  rd_data, busy, frame_done
  );

  modport slave (
    input  ports_flat, freeze, rd_port, rd_digit,
    output rd_data, busy, frame_done
  );
endinterface

// File: rtl/vga_port_monitor.sv
// -----------------------------------------------------------------------------
// vga_port_monitor
//   Snapshots NUM_PORTS binary ports every REFRESH_DIV cycles, converts each
//   one to DIGITS decimal digits with a sequential shift-add-3 engine and
//   publishes the complete frame to a display buffer in a single cycle, so
//   the VGA renderer never sees a half-updated frame.
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    vga_port_monitor_if.slave (ports, freeze, read port, status)
//
//   Build option
//     VGA_MON_LEADING_BLANK_EN : when defined, leading zero digits of each
//     port (never the ones digit) are published as blank (6'h20).
// -----------------------------------------------------------------------------
module vga_port_monitor #(
  parameter int NUM_PORTS   = 3,
  parameter int PORT_W      = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 1_000_000
) (
  input logic               clk,
  input logic               rst_n,
  vga_port_monitor_if.slave bus
);

  localparam int PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BIT_W  = (PORT_W > 1) ? $clog2(PORT_W) : 1;
  localparam int BCD_W  = 4 * DIGITS;
  localparam logic [5:0] BLANK = 6'h20;

  // Decimal digits needed for the largest PORT_W-bit value.
  function automatic int min_digits(input int w);
    longint unsigned v;
    int              d;
    v = (64'd1 << w) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d++;
    end
    return d;
  endfunction

  if (DIGITS < min_digits(PORT_W)) begin : g_bad_digits
    $error("vga_port_monitor: DIGITS=%0d too small for PORT_W=%0d", DIGITS, PORT_W);
  end

  if (REFRESH_DIV < NUM_PORTS * (PORT_W + 2) + 2) begin : g_bad_div
    $error("vga_port_monitor: REFRESH_DIV=%0d shorter than one frame", REFRESH_DIV);
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   refresh_cnt;
  logic [PIDX_W-1:0]  idx;
  logic [BIT_W-1:0]   bit_cnt;
  logic [PORT_W-1:0]  bin_sr;
  logic [BCD_W-1:0]   bcd;
  logic               busy_r;
  logic               frame_done_r;
  logic [5:0]         rd_data_r;

  logic [PORT_W-1:0]  shadow      [NUM_PORTS];
  logic [BCD_W-1:0]   work        [NUM_PORTS];
  logic [5:0]         disp        [NUM_PORTS][DIGITS];
  logic [5:0]         frame_codes [NUM_PORTS][DIGITS];

  logic               tick;
  logic               last_bit;
  logic               last_port;
  logic [BCD_W-1:0]   bcd_adj;

  assign tick      = (32'(refresh_cnt) == REFRESH_DIV - 1);
  assign last_bit  = (32'(bit_cnt) == PORT_W - 1);
  assign last_port = (32'(idx) == NUM_PORTS - 1);

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path
    // leaves it unassigned, which would infer a latch.
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // Frame as it will be published by the final STORE: the row of the port
  // being stored in that same cycle comes straight from the accumulator.
  always_comb begin
    logic [3:0] nib;
`ifdef VGA_MON_LEADING_BLANK_EN
    logic       leading;
`endif
    nib = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int d = 0; d < DIGITS; d++) begin
        nib = (32'(idx) == p) ? bcd[4*d +: 4] : work[p][4*d +: 4];
        frame_codes[p][d] = {2'b00, nib};
      end
    end
`ifdef VGA_MON_LEADING_BLANK_EN
    leading = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      leading = 1'b1;
      // Most significant digit down to the tens; the ones digit always shows.
      for (int d = DIGITS - 1; d > 0; d--) begin
        if (leading && frame_codes[p][d] == 6'h00) frame_codes[p][d] = BLANK;
        else                                       leading = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      refresh_cnt  <= '0;
      idx          <= '0;
      bit_cnt      <= '0;
      bin_sr       <= '0;
      bcd          <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      // NOTE: these buffers are register arrays, not RAM, and the renderer
      // must read zeros after reset, so every entry is cleared here.
      for (int p = 0; p < NUM_PORTS; p++) begin
        shadow[p] <= '0;
        work[p]   <= '0;
        for (int d = 0; d < DIGITS; d++) disp[p][d] <= 6'h00;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register sees the pre-edge value of every other register.
      frame_done_r <= 1'b0;
      refresh_cnt  <= tick ? '0 : refresh_cnt + CNT_W'(1);

      case (state)
        S_IDLE: begin
          // Ticks while frozen (or while converting) are simply dropped.
          if (tick && !bus.freeze) begin
            for (int p = 0; p < NUM_PORTS; p++) shadow[p] <= bus.ports_flat[p*PORT_W +: PORT_W];
            idx    <= '0;
            busy_r <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          bin_sr  <= shadow[idx];
          bcd     <= '0;
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
          bit_cnt       <= bit_cnt + BIT_W'(1);
          if (last_bit) state <= S_STORE;
        end
        S_STORE: begin
          work[idx] <= bcd;
          if (last_port) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
              for (int d = 0; d < DIGITS; d++) disp[p][d] <= frame_codes[p][d];
            end
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
            state        <= S_IDLE;
          end else begin
            idx   <= idx + PIDX_W'(1);
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Renderer read port, one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= 6'h00;
    end else if (32'(bus.rd_port) >= NUM_PORTS || 32'(bus.rd_digit) >= DIGITS) begin
      rd_data_r <= BLANK;
    end else begin
      rd_data_r <= disp[bus.rd_port][bus.rd_digit];
    end
  end

  assign bus.rd_data    = rd_data_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_vga_port_monitor.sv
module tb_vga_port_monitor;

  localparam int DIV = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n;
  logic rst_b_n;

  vga_port_monitor_if #(.NUM_PORTS(3), .PORT_W(8),  .DIGITS(3)) bus_a ();
  vga_port_monitor_if #(.NUM_PORTS(2), .PORT_W(16), .DIGITS(5)) bus_b ();

  vga_port_monitor #(.NUM_PORTS(3), .PORT_W(8), .DIGITS(3), .REFRESH_DIV(DIV)) dut_a (
    .clk  (clk),
    .rst_n(rst_a_n),
    .bus  (bus_a)
  );

  vga_port_monitor #(.NUM_PORTS(2), .PORT_W(16), .DIGITS(5), .REFRESH_DIV(DIV)) dut_b (
    .clk  (clk),
    .rst_n(rst_b_n),
    .bus  (bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Reference digit code: decimal digit d of val, blanked when it is a
  // leading zero and the blanking build is selected.
  function automatic logic [5:0] exp_code(input int unsigned val, input int d);
    int unsigned pw;
    int unsigned nib;
    pw = 1;
    for (int i = 0; i < d; i++) pw = pw * 10;
    nib = (val / pw) % 10;
`ifdef VGA_MON_LEADING_BLANK_EN
    if (d > 0 && val < pw) return 6'h20;
`endif
    return 6'(nib);
  endfunction

  // ---------------- scoreboards ----------------
  logic [5:0] q_a[$];
  logic [5:0] q_b[$];
  string      qn_a[$];
  string      qn_b[$];
  logic       req_a = 1'b0, vld_a = 1'b0;
  logic       req_b = 1'b0, vld_b = 1'b0;

  always @(posedge clk) begin
    vld_a <= req_a;
    vld_b <= req_b;
  end

  int run_a = 0, last_run_a = 0, busy_tot_a = 0, fd_a = 0;
  int run_b = 0, last_run_b = 0;
  logic [5:0] exp_a, exp_b;
  string      nm_a, nm_b;

  always @(negedge clk) begin
    if (vld_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_a_underflow: read result with no expected value");
      end else begin
        exp_a = q_a.pop_front();
        nm_a  = qn_a.pop_front();
        check(nm_a, 32'(bus_a.rd_data), 32'(exp_a));
      end
    end
    if (bus_a.busy) begin
      run_a++;
      busy_tot_a++;
    end else if (run_a != 0) begin
      last_run_a = run_a;
      run_a      = 0;
    end
    if (bus_a.frame_done) begin
      fd_a++;
      check("fd_a_busy_low", 32'(bus_a.busy), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (vld_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_b_underflow: read result with no expected value");
      end else begin
        exp_b = q_b.pop_front();
        nm_b  = qn_b.pop_front();
        check(nm_b, 32'(bus_b.rd_data), 32'(exp_b));
      end
    end
    if (bus_b.busy) begin
      run_b++;
    end else if (run_b != 0) begin
      last_run_b = run_b;
      run_b      = 0;
    end
    if (bus_b.frame_done) check("fd_b_busy_low", 32'(bus_b.busy), 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue_read(input bit sel, input int port, input int digit,
                            input logic [5:0] exp, input string name);
    if (!sel) begin
      bus_a.rd_port  = 2'(port);
      bus_a.rd_digit = 2'(digit);
      q_a.push_back(exp);
      qn_a.push_back(name);
      req_a = 1'b1;
    end else begin
      bus_b.rd_port  = 1'(port);
      bus_b.rd_digit = 3'(digit);
      q_b.push_back(exp);
      qn_b.push_back(name);
      req_b = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!sel) req_a = 1'b0;
    else      req_b = 1'b0;
  endtask

  // Returns #1 after the edge that ends the frame_done cycle.
  task automatic wait_fd(input bit sel, input int budget, input string name);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = sel ? bus_b.frame_done : bus_a.frame_done;
    end
    check(name, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Returns at the falling edge of the first LOAD cycle.
  task automatic wait_busy_a(input int budget, input string name);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = bus_a.busy;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  bit done_b = 1'b0;

  // ---------------- wide configuration ----------------
  initial begin
    rst_b_n          = 1'b0;
    bus_b.freeze     = 1'b0;
    bus_b.ports_flat = {16'd9, 16'd65535};
    bus_b.rd_port    = '0;
    bus_b.rd_digit   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_b_n = 1'b1;
    wait_fd(1, 300, "b_frame_done");
    check("b_busy_len", 32'(last_run_b), 32'd36);
    for (int d = 0; d < 5; d++) issue_read(1, 0, d, exp_code(65535, d), $sformatf("b_p0_d%0d", d));
    for (int d = 0; d < 5; d++) issue_read(1, 1, d, exp_code(9, d), $sformatf("b_p1_d%0d", d));
    issue_read(1, 0, 5, 6'h20, "b_oor_digit5");
    issue_read(1, 1, 7, 6'h20, "b_oor_digit7");
    repeat (2) @(posedge clk);
    done_b = 1'b1;
  end

  // ---------------- default configuration ----------------
  int vals1[3] = '{0, 255, 128};
  int vals3[3] = '{5, 200, 99};
  int fd_before, bt_before;

  initial begin
    rst_a_n          = 1'b0;
    bus_a.freeze     = 1'b0;
    bus_a.ports_flat = {8'd128, 8'd255, 8'd0};
    bus_a.rd_port    = '0;
    bus_a.rd_digit   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_data",    32'(bus_a.rd_data),    32'h00);
    check("rst_busy",       32'(bus_a.busy),       32'd0);
    check("rst_frame_done", 32'(bus_a.frame_done), 32'd0);
    @(posedge clk);
    #1;
    rst_a_n = 1'b1;

    // First frame; port1 changes after the snapshot.
    wait_busy_a(200, "f1_start");
    repeat (3) @(posedge clk);
    #1;
    bus_a.ports_flat[15:8] = 8'd7;
    issue_read(0, 1, 0, 6'h00, "read_during_busy");
    wait_fd(0, 100, "f1_done");
    check("f1_busy_len", 32'(last_run_a), 32'd30);
    for (int p = 0; p < 3; p++)
      for (int d = 0; d < 3; d++)
        issue_read(0, p, d, exp_code(vals1[p], d), $sformatf("f1_p%0d_d%0d", p, d));
    issue_read(0, 3, 0, 6'h20, "oor_port3");
    issue_read(0, 0, 3, 6'h20, "oor_digit3");
    issue_read(0, 2, 0, exp_code(128, 0), "after_oor");

    // Second frame picks up the new port1 value.
    wait_fd(0, 150, "f2_done");
    for (int d = 0; d < 3; d++) issue_read(0, 1, d, exp_code(7, d), $sformatf("f2_p1_d%0d", d));
    issue_read(0, 2, 1, exp_code(128, 1), "f2_p2_d1");

    // Freeze across two ticks.
    bus_a.freeze = 1'b1;
    fd_before    = fd_a;
    bt_before    = busy_tot_a;
    bus_a.ports_flat[7:0] = 8'd42;
    repeat (140) @(posedge clk);
    #1;
    check("freeze_no_frame", 32'(fd_a),       32'(fd_before));
    check("freeze_no_busy",  32'(busy_tot_a), 32'(bt_before));
    issue_read(0, 0, 0, exp_code(0, 0), "freeze_hold_p0");
    issue_read(0, 1, 0, exp_code(7, 0), "freeze_hold_p1");
    bus_a.freeze = 1'b0;
    wait_fd(0, 150, "unfreeze_done");
    for (int d = 0; d < 3; d++) issue_read(0, 0, d, exp_code(42, d), $sformatf("unfz_p0_d%0d", d));

    // Asynchronous reset during port1 SHIFT.
    wait_busy_a(150, "f4_start");
    bus_a.ports_flat = {8'd99, 8'd200, 8'd5};
    repeat (12) @(posedge clk);
    #1;
    issue_read(0, 1, 0, exp_code(7, 0), "pre_rst_read");
    @(negedge clk);
    #1;
    rst_a_n = 1'b0;
    #1;
    check("mid_rst_busy",       32'(bus_a.busy),       32'd0);
    check("mid_rst_frame_done", 32'(bus_a.frame_done), 32'd0);
    check("mid_rst_rd_data",    32'(bus_a.rd_data),    32'h00);
    @(posedge clk);
    #1;
    rst_a_n = 1'b1;
    issue_read(0, 1, 0, 6'h00, "post_rst_display");
    wait_fd(0, 200, "f5_done");
    check("f5_busy_len", 32'(last_run_a), 32'd30);
    for (int p = 0; p < 3; p++)
      for (int d = 0; d < 3; d++)
        issue_read(0, p, d, exp_code(vals3[p], d), $sformatf("f5_p%0d_d%0d", p, d));

    begin
      int n;
      n = 0;
      while (!done_b && n < 2000) begin
        @(posedge clk);
        n++;
      end
    end
    check("b_sequence_done", 32'(done_b), 32'd1);
    repeat (3) @(posedge clk);
    check("sb_a_drained", 32'(q_a.size()), 32'd0);
    check("sb_b_drained", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
